// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

    // Architectural register-specifier width (16 registers, r0 reads as zero)
    localparam int REG_W_DEF = 4;

    // Instruction word that flush/bubble consumers load in place of a real instruction
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MULDIV = 2'd1,
        ST_HALTED = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - ID/EX status inputs and PC/pipeline-register controls (PIPE_HAZARD_PERF_EN adds stall_cycles)
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = pipe_ctrl_pkg::REG_W_DEF
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_is_muldiv;
    logic             id_is_halt;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rd;
    logic             ex_branch_taken;
    logic             resume;

    logic             stop_pc;
    logic             halt;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             ex_hold;
`ifdef PIPE_HAZARD_PERF_EN
    logic [15:0]      stall_cycles;
`endif

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_muldiv, id_is_halt,
        output ex_mem_read, ex_rd, ex_branch_taken, resume,
`ifdef PIPE_HAZARD_PERF_EN
        input  stall_cycles,
`endif
        input  stop_pc, halt, ifid_write, ifid_flush, idex_bubble, ex_hold
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_muldiv, id_is_halt,
        input  ex_mem_read, ex_rd, ex_branch_taken, resume,
`ifdef PIPE_HAZARD_PERF_EN
        output stall_cycles,
`endif
        output stop_pc, halt, ifid_write, ifid_flush, idex_bubble, ex_hold
    );

endinterface

// File: rtl/hazard_cmp.sv
// rtl/hazard_cmp.sv - combinational load-use hazard detector with r0 exclusion
module hazard_cmp #(
    parameter int REG_W = pipe_ctrl_pkg::REG_W_DEF
) (
    input  logic             mem_read,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             uses_rs,
    input  logic             uses_rt,
    output logic             hazard
);

    // A load into r0 produces nothing a consumer could depend on
    always_comb begin
        hazard = mem_read && (rd != '0) &&
                 ((uses_rs && (rs == rd)) || (uses_rt && (rt == rd)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline (optional PIPE_HAZARD_PERF_EN stall counter)
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W         = REG_W_DEF,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    ctrl_state_t state, next_state;
    logic [3:0]  cnt, next_cnt;
    logic        load_use;

    hazard_cmp #(.REG_W(REG_W)) u_hazard_cmp (
        .mem_read (bus.ex_mem_read),
        .rd       (bus.ex_rd),
        .rs       (bus.id_rs),
        .rt       (bus.id_rt),
        .uses_rs  (bus.id_uses_rs),
        .uses_rt  (bus.id_uses_rt),
        .hazard   (load_use)
    );

    // State and mul/div countdown register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state and control outputs; RUN resolves events by fixed priority
    always_comb begin
        next_state      = state;
        next_cnt        = cnt;
        bus.stop_pc     = 1'b0;
        bus.halt        = 1'b0;
        bus.ifid_write  = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_bubble = 1'b0;
        bus.ex_hold     = 1'b0;
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    if (bus.ex_branch_taken) begin
                        // Instruction in ID is squashed, so its halt/muldiv flags do not matter
                        bus.ifid_flush  = 1'b1;
                        bus.idex_bubble = 1'b1;
                    end else if (load_use) begin
                        bus.stop_pc     = 1'b1;
                        bus.ifid_write  = 1'b0;
                        bus.idex_bubble = 1'b1;
                    end else if (bus.id_is_halt) begin
                        bus.stop_pc     = 1'b1;
                        bus.ifid_write  = 1'b0;
                        bus.idex_bubble = 1'b1;
                        next_state      = ST_HALTED;
                    end else if (bus.id_is_muldiv) begin
                        // The mul/div itself advances to EX this cycle; holding starts next cycle
                        next_state = ST_MULDIV;
                        next_cnt   = 4'(MULDIV_CYCLES - 1);
                    end
                end
                ST_MULDIV: begin
                    bus.ex_hold    = 1'b1;
                    bus.stop_pc    = 1'b1;
                    bus.ifid_write = 1'b0;
                    next_cnt       = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        next_state = ST_RUN;
                    end
                end
                ST_HALTED: begin
                    bus.halt        = 1'b1;
                    bus.stop_pc     = 1'b1;
                    bus.ifid_write  = 1'b0;
                    bus.idex_bubble = 1'b1;
                    if (bus.resume) begin
                        next_state = ST_RUN;
                    end
                end
                default: begin
                    next_state = ST_RUN;
                end
            endcase
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [15:0] stall_cnt;

    // Saturating count of PC-stall cycles; branch flushes never raise stop_pc
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (bus.stop_pc && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl (PIPE_HAZARD_PERF_EN enables counter checks)
module tb_pipe_hazard_ctrl;

    localparam int MD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_W(4)) bus ();

    pipe_hazard_ctrl #(.REG_W(4), .MULDIV_CYCLES(MD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [5:0]  ctl;   // {stop_pc, halt, ifid_write, ifid_flush, idex_bubble, ex_hold}
        logic [15:0] perf;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: "halted" flag and number of hold cycles still owed to a mul/div
    bit   m_halted = 0;
    int   m_md_left = 0;
    int   m_perf = 0;

    localparam logic [5:0] IDLE  = 6'b001000;
    localparam logic [5:0] FLUSH = 6'b001110;
    localparam logic [5:0] STALL = 6'b100010;
    localparam logic [5:0] HOLD  = 6'b100001;
    localparam logic [5:0] HALTD = 6'b110010;

    task automatic cyc(input bit r, input bit br, input bit mr, input logic [3:0] rd,
                       input logic [3:0] rs, input bit urs, input logic [3:0] rt, input bit urt,
                       input bit hl, input bit md, input bit rsm);
        exp_t e;
        bit   hz;
        rst                 = r;
        bus.ex_branch_taken = br;
        bus.ex_mem_read     = mr;
        bus.ex_rd           = rd;
        bus.id_rs           = rs;
        bus.id_uses_rs      = urs;
        bus.id_rt           = rt;
        bus.id_uses_rt      = urt;
        bus.id_is_halt      = hl;
        bus.id_is_muldiv    = md;
        bus.resume          = rsm;
        hz = mr && (rd != 0) && ((urs && rs == rd) || (urt && rt == rd));
        e.perf = 16'(m_perf);
        if (r) begin
            e.ctl = IDLE;
            m_halted = 0; m_md_left = 0;
        end else if (m_md_left > 0) begin
            e.ctl = HOLD;
            m_md_left--;
        end else if (m_halted) begin
            e.ctl = HALTD;
            if (rsm) m_halted = 0;
        end else if (br) begin
            e.ctl = FLUSH;
        end else if (hz) begin
            e.ctl = STALL;
        end else if (hl) begin
            e.ctl = STALL;
            m_halted = 1;
        end else if (md) begin
            e.ctl = IDLE;
            m_md_left = MD - 1;
        end else begin
            e.ctl = IDLE;
        end
        exp_q.push_back(e);
        @(posedge clk);
        if (r) m_perf = 0;
        else if (e.ctl[5] && m_perf < 65535) m_perf++;
        #1;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are combinational, so sample mid-cycle and compare against the queue
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [5:0] act;
            e = exp_q.pop_front();
            act = {bus.stop_pc, bus.halt, bus.ifid_write, bus.ifid_flush, bus.idex_bubble, bus.ex_hold};
            vectors++;
            if (act !== e.ctl) begin
                miscompares++;
                $display("FAIL ctl vec=%0d got=%b want=%b (stop,halt,ifw,flush,bubble,hold)", vectors, act, e.ctl);
            end
`ifdef PIPE_HAZARD_PERF_EN
            vectors++;
            if (bus.stall_cycles !== e.perf) begin
                miscompares++;
                $display("FAIL stall_cycles vec=%0d got=%h want=%h", vectors, bus.stall_cycles, e.perf);
            end
`endif
        end
    end

    initial begin
        @(posedge clk); #1;
        // Reset held with branch and halt requests present
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        quiet(1);
        // Load-use on rs, then r0 destination, then unused source
        cyc(0, 0, 1, 3, 3, 1, 0, 0, 0, 0, 0);
        quiet(1);
        cyc(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 3, 3, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 5, 1, 0, 5, 1, 0, 0, 0);
        // Mul/div occupancy
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 1, 2, 2, 1, 0, 0, 1, 1, 0);
        quiet(4);
        // Branch wins over halt
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        quiet(1);
        // Halt, long wait, resume
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        quiet(2);
        // Resume outside HALTED is ignored; reset from HALTED and from MULDIV
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        quiet(2);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        quiet(2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        quiet(1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        quiet(2);
        // Randomised traffic with small register indices to make collisions frequent
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 2) == 0),
                4'($urandom_range(0, 3)),
                4'($urandom_range(0, 3)), 1'($urandom),
                4'($urandom_range(0, 3)), 1'($urandom),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) == 0));
        end
`ifdef PIPE_HAZARD_PERF_EN
        // One load-use stall plus one mul/div gives four counted cycles
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 3, 3, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        quiet(3);
        // Saturation
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 70000; i++) begin
            if (i < 69990) begin
                exp_t e;
                e.ctl = HALTD; e.perf = 16'(m_perf);
                exp_q.push_back(e);
                @(posedge clk);
                if (m_perf < 65535) m_perf++;
                #1;
            end else begin
                cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            end
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        quiet(2);
`endif
        @(negedge clk);
        @(posedge clk); #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
